// File: rtl/serial_to_parallel_gate_loader_if.sv
// Serial-beat input and parallel word-pair output bundle for serial_to_parallel_gate_loader.
// The slave modport is the deserializer's view and the master modport is the producer/consumer view.
interface serial_to_parallel_gate_loader_if #(
    parameter int unsigned S = 3
);
    logic              s_valid;
    logic              s_ready;
    logic              s_bit1;
    logic              s_bit2;
    logic              m_valid;
    logic              m_ready;
    logic [2**S-1:0]   m_in1;
    logic [2**S-1:0]   m_in2;
    logic [S:0]        fill_cnt;

    modport master (
        output s_valid, s_bit1, s_bit2, m_ready,
        input  s_ready, m_valid, m_in1, m_in2, fill_cnt
    );

    modport slave (
        input  s_valid, s_bit1, s_bit2, m_ready,
        output s_ready, m_valid, m_in1, m_in2, fill_cnt
    );
endinterface

// File: rtl/serial_to_parallel_gate_loader.sv
// Bit-serial deserializer: assembles two W-bit operand words LSB-first and presents them
// on a valid/ready port, with one pending word slot so the serial side rarely stalls.
module serial_to_parallel_gate_loader #(
    parameter int unsigned S = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    serial_to_parallel_gate_loader_if.slave    bus
);
    localparam int unsigned W = 2**S;
    localparam logic [S:0]  CNT_LAST = (S+1)'(W - 1);

    typedef enum logic {
        FILL,
        PEND
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_asm1;
    logic [W-1:0]   r_asm2;
    logic [S:0]     r_cnt;
    logic [W-1:0]   r_m_in1;
    logic [W-1:0]   r_m_in2;
    logic           r_m_valid;

    logic           w_s_ready;
    logic           w_accept;
    logic           w_last;
    logic           w_load_new;
    logic           w_load_asm;
    logic [W-1:0]   w_word1;
    logic [W-1:0]   w_word2;

    // Assembly registers with the incoming beat merged at the current index.
    always_comb begin
        w_word1 = r_asm1;
        w_word2 = r_asm2;
        for (int unsigned k = 0; k < W; k++) begin
            if (r_cnt == (S+1)'(k)) begin
                w_word1[k] = bus.s_bit1;
                w_word2[k] = bus.s_bit2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_ready   = 1'b0;
        w_load_new  = 1'b0;
        w_load_asm  = 1'b0;
        w_accept    = 1'b0;
        w_last      = (r_cnt == CNT_LAST);
        case (r_state)
            FILL: begin
                w_s_ready = !rst;
                w_accept  = bus.s_valid && w_s_ready;
                if (w_accept && w_last) begin
                    if (!r_m_valid || bus.m_ready) begin
                        w_load_new = 1'b1;
                    end else begin
                        w_state_nxt = PEND;
                    end
                end
            end
            PEND: begin
                if (bus.m_ready) begin
                    w_load_asm  = 1'b1;
                    w_state_nxt = FILL;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_asm1    <= '0;
            r_asm2    <= '0;
            r_cnt     <= '0;
            r_m_in1   <= '0;
            r_m_in2   <= '0;
            r_m_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_asm1 <= w_word1;
                r_asm2 <= w_word2;
                r_cnt  <= w_last ? '0 : r_cnt + (S+1)'(1);
            end
            // A fresh load always wins over the drain so a same-edge handshake leaves no bubble.
            if (w_load_new) begin
                r_m_in1   <= w_word1;
                r_m_in2   <= w_word2;
                r_m_valid <= 1'b1;
            end else if (w_load_asm) begin
                r_m_in1   <= r_asm1;
                r_m_in2   <= r_asm2;
                r_m_valid <= 1'b1;
            end else if (r_m_valid && bus.m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign bus.s_ready  = w_s_ready;
    assign bus.m_valid  = r_m_valid;
    assign bus.m_in1    = r_m_in1;
    assign bus.m_in2    = r_m_in2;
    assign bus.fill_cnt = r_cnt;
endmodule

// File: tb/tb_serial_to_parallel_gate_loader.sv
// Self-checking bench: random and directed beats on an S=3 and an S=0 instance, checked
// against a queue-based model of accepted words and the single visible output word.
module tb_serial_to_parallel_gate_loader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_to_parallel_gate_loader_if #(.S(3)) if8 ();
    serial_to_parallel_gate_loader_if #(.S(0)) if1 ();

    serial_to_parallel_gate_loader #(.S(3)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));
    serial_to_parallel_gate_loader #(.S(0)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    int errors = 0;
    int checks = 0;

    // Model: queue of completed words (front = word on the output, at most two), partial word bits.
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    logic [7:0] hold1, hold2, part1, part2;
    int         n;

    function automatic logic [21:0] model_vec();
        logic [7:0] e1, e2;
        e1 = (q1.size() != 0) ? q1[0] : hold1;
        e2 = (q2.size() != 0) ? q2[0] : hold2;
        return {(!rst && q1.size() < 2), (q1.size() != 0), e1, e2, 4'(n)};
    endfunction

    function automatic logic [21:0] dut_vec();
        return {if8.s_ready, if8.m_valid, if8.m_in1, if8.m_in2, if8.fill_cnt};
    endfunction

    task automatic model_edge();
        bit rdy;
        if (rst) begin
            q1.delete(); q2.delete();
            hold1 = '0; hold2 = '0; part1 = '0; part2 = '0; n = 0;
        end else begin
            rdy = (q1.size() < 2);
            if (q1.size() != 0 && if8.m_ready) begin
                hold1 = q1.pop_front();
                hold2 = q2.pop_front();
            end
            if (if8.s_valid && rdy) begin
                part1[n] = if8.s_bit1;
                part2[n] = if8.s_bit2;
                n++;
                if (n == 8) begin
                    q1.push_back(part1);
                    q2.push_back(part2);
                    part1 = '0; part2 = '0; n = 0;
                end
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic beat8(input logic v, input logic b1, input logic b2, input logic mr);
        if8.s_valid = v; if8.s_bit1 = b1; if8.s_bit2 = b2; if8.m_ready = mr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        beat8(1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        checks++;
        if ({if8.s_ready, if8.m_valid, if8.fill_cnt, if8.m_in1, if8.m_in2} !== 22'd0) begin
            errors++;
            $display("FAIL reset_values got rdy=%b v=%b cnt=%0d in1=%h in2=%h exp all 0",
                     if8.s_ready, if8.m_valid, if8.fill_cnt, if8.m_in1, if8.m_in2);
        end
        rst = 1'b0;
        beat8(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (if8.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got=%b exp=1", if8.s_ready);
        end
        tick();
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL reset_idle got=%h exp=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_basic();
        logic [7:0] a, b;
        int vcount;
        a = 8'hA5; b = 8'h3C; vcount = 0;
        for (int k = 0; k < 10; k++) begin
            if (k < 8) beat8(1'b1, a[k], b[k], 1'b1);
            else       beat8(1'b0, 1'b0, 1'b0, 1'b1);
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL basic k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
            if (if8.m_valid) vcount++;
            if (k == 7) begin
                checks++;
                if (!(if8.m_valid === 1'b1 && if8.m_in1 === 8'hA5 && if8.m_in2 === 8'h3C
                      && (if8.m_in1 & if8.m_in2) === 8'h24)) begin
                    errors++;
                    $display("FAIL basic_word got v=%b in1=%h in2=%h and=%h exp v=1 a5 3c 24",
                             if8.m_valid, if8.m_in1, if8.m_in2, if8.m_in1 & if8.m_in2);
                end
            end
        end
        checks++;
        if (vcount != 1) begin
            errors++;
            $display("FAIL basic_valid_cycles got=%0d exp=1", vcount);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, b;
        bit dropped;
        a = {8'h01, 8'hFF}; b = {8'h80, 8'h0F}; dropped = 0;
        for (int k = 0; k < 17; k++) begin
            if (k < 16) beat8(1'b1, a[k], b[k], 1'b1);
            else        beat8(1'b0, 1'b0, 1'b0, 1'b1);
            if (k < 16 && if8.s_ready !== 1'b1) dropped = 1;
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL b2b k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
            if (k == 7 || k == 15) begin
                checks++;
                if ({if8.m_valid, if8.m_in1, if8.m_in2} !== {1'b1, (k == 7) ? 16'hFF0F : 16'h0180}) begin
                    errors++;
                    $display("FAIL b2b_word k=%0d got v=%b in1=%h in2=%h", k, if8.m_valid, if8.m_in1, if8.m_in2);
                end
            end
        end
        checks++;
        if (dropped) begin
            errors++;
            $display("FAIL b2b_ready_drop got=1 exp=0");
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] a, b;
        a = {8'h56, 8'h12}; b = {8'h78, 8'h34};
        for (int k = 0; k < 16; k++) begin
            beat8(1'b1, a[k], b[k], 1'b0);
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL bp_fill k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
        end
        checks++;
        if ({if8.s_ready, if8.fill_cnt, if8.m_in1, if8.m_valid} !== {1'b0, 4'd0, 8'h12, 1'b1}) begin
            errors++;
            $display("FAIL bp_pend got rdy=%b cnt=%0d in1=%h v=%b exp 0 0 12 1",
                     if8.s_ready, if8.fill_cnt, if8.m_in1, if8.m_valid);
        end
        beat8(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL bp_hold got=%h exp=%h", dut_vec(), model_vec());
        end
        beat8(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checks++;
        if ({if8.m_valid, if8.m_in1, if8.m_in2, if8.s_ready} !== {1'b1, 8'h56, 8'h78, 1'b1}) begin
            errors++;
            $display("FAIL bp_release got v=%b in1=%h in2=%h rdy=%b exp 1 56 78 1",
                     if8.m_valid, if8.m_in1, if8.m_in2, if8.s_ready);
        end
        for (int k = 0; k < 3; k++) begin
            beat8(1'b0, 1'b0, 1'b0, (k == 2));
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL bp_drain k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_gapped();
        logic [7:0] a, b;
        a = 8'hC3; b = 8'h99;
        for (int k = 0; k < 8; k++) begin
            int gap;
            gap = int'($urandom_range(1, 3));
            for (int g = 0; g <= gap; g++) begin
                if (g < gap) beat8(1'b0, 1'($urandom), 1'($urandom), 1'b1);
                else         beat8(1'b1, a[k], b[k], 1'b1);
                tick();
                checks++;
                if (dut_vec() !== model_vec()) begin
                    errors++;
                    $display("FAIL gap k=%0d g=%0d got=%h exp=%h", k, g, dut_vec(), model_vec());
                end
            end
        end
        checks++;
        if ({if8.m_valid, if8.m_in1, if8.m_in2} !== {1'b1, 8'hC3, 8'h99}) begin
            errors++;
            $display("FAIL gap_word got v=%b in1=%h in2=%h exp 1 c3 99", if8.m_valid, if8.m_in1, if8.m_in2);
        end
        beat8(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_reset_mid();
        logic [7:0] a, b;
        a = 8'h0F; b = 8'hF0;
        for (int k = 0; k < 5; k++) begin
            beat8(1'b1, 1'b1, 1'b0, 1'b0);
            tick();
        end
        rst = 1'b1;
        beat8(1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        checks++;
        if ({if8.s_ready, if8.m_valid, if8.fill_cnt} !== 6'd0) begin
            errors++;
            $display("FAIL rstmid_during got rdy=%b v=%b cnt=%0d exp 0 0 0", if8.s_ready, if8.m_valid, if8.fill_cnt);
        end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            beat8(1'b1, a[k], b[k], 1'b1);
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL rstmid k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
        end
        checks++;
        if ({if8.m_valid, if8.m_in1, if8.m_in2} !== {1'b1, 8'h0F, 8'hF0}) begin
            errors++;
            $display("FAIL rstmid_word got v=%b in1=%h in2=%h exp 1 0f f0", if8.m_valid, if8.m_in1, if8.m_in2);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            beat8(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0));
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL random k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
            end
        end
        beat8(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_s0();
        logic [2:0] b1s, b2s;
        logic x1, x2;
        b1s = 3'b011; b2s = 3'b101;
        for (int k = 0; k < 16; k++) begin
            if (k < 3) begin x1 = b1s[k]; x2 = b2s[k]; end
            else       begin x1 = 1'($urandom); x2 = 1'($urandom); end
            if1.s_valid = 1'b1; if1.s_bit1 = x1; if1.s_bit2 = x2; if1.m_ready = 1'b1;
            tick();
            checks++;
            if ({if1.m_valid, if1.m_in1, if1.m_in2, if1.fill_cnt, if1.s_ready} !== {1'b1, x1, x2, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL s0 k=%0d got v=%b in1=%b in2=%b cnt=%0d rdy=%b exp 1 %b %b 0 1",
                         k, if1.m_valid, if1.m_in1, if1.m_in2, if1.fill_cnt, if1.s_ready, x1, x2);
            end
        end
        if1.s_valid = 1'b0;
        tick();
        checks++;
        if (if1.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL s0_drain got v=%b exp 0", if1.m_valid);
        end
    endtask

    initial begin
        rst = 1'b1;
        beat8(1'b0, 1'b0, 1'b0, 1'b0);
        if1.s_valid = 1'b0; if1.s_bit1 = 1'b0; if1.s_bit2 = 1'b0; if1.m_ready = 1'b0;
        hold1 = '0; hold2 = '0; part1 = '0; part2 = '0; n = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_gapped();
        test_reset_mid();
        test_random();
        test_s0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
